mult_div_unit: RTL and testbench

- Iterative signed multiply/divide unit for the multicycle MIPS datapath.
- Sits between the MDSrcA/MDSrcB operand muxes and the HI/LO registers.
- The control unit pulses start, waits for done, then loads HI/LO from hi_out/lo_out.
- Raises div_zero so the control unit can vector to the divide-by-zero exception handler (address 0xFF).

---
 rtl/mult_div_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative signed multiply / divide unit for the multicycle MIPS datapath.
// Operands come from the MDSrcA/MDSrcB muxes; the control unit pulses start,
// waits for done, then loads HI/LO from hi_out/lo_out.
//
// Multiply: radix-2 Booth, one iteration per cycle, WIDTH iterations.
// Divide:   restoring shift-subtract on magnitudes, one quotient bit per
//           cycle, WIDTH iterations, then sign correction (quotient truncates
//           toward zero, remainder follows the dividend's sign).
// Divide by zero skips the iterations, pulses done and div_zero together one
// cycle after start and leaves hi_out/lo_out unchanged.
//
// Optional feature macro: MD_UNSIGNED_EN
//   Defined   -> adds op_unsigned; when 1 at start the operation is multu/divu.
//   Undefined -> no op_unsigned port; every operation is signed.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   one-cycle request, sampled only in IDLE
//   op_div       in   0 = mult, 1 = div (sampled with start)
//   op_unsigned  in   unsigned operation (only with MD_UNSIGNED_EN)
//   src_a        in   multiplicand / dividend
//   src_b        in   multiplier / divisor
//   hi_out       out  product high half or remainder
//   lo_out       out  product low half or quotient
//   busy         out  high while iterating (MULT / DIV)
//   done         out  one-cycle completion pulse
//   div_zero     out  one-cycle pulse with done on divide by zero
//   o_dbg_state  out  current FSM state (0 IDLE, 1 MULT, 2 DIV, 3 DONE)
//
// Handshake: start is honoured only when the unit is in IDLE; a start seen in
// any other state is dropped, never queued. Results are valid from the cycle
// done is high and hold until the next completed operation or reset.
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
`ifdef MD_UNSIGNED_EN
    input  logic             op_unsigned,
`endif
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    // Shared datapath: r_acc is the Booth accumulator or the partial
    // remainder, r_q the multiplier or dividend/quotient shift register.
    // One extra accumulator bit absorbs Booth overflow for -2^(W-1) and the
    // carry of the unsigned add / the shifted remainder.
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH-1:0] r_m;
    logic             r_uns;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_uns;
`ifdef MD_UNSIGNED_EN
    assign w_uns = op_unsigned;
`else
    assign w_uns = 1'b0;
`endif

    // Operand magnitudes for division; -2^(W-1) maps to 2^(W-1) unsigned.
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    assign w_a_mag = (!w_uns && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_b_mag = (!w_uns && src_b[WIDTH-1]) ? -src_b : src_b;

    // ---------------- multiply iteration ----------------
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_mul_sum;
    logic             w_mul_fill;
    logic [WIDTH:0]   w_mul_acc_nx;
    logic [WIDTH-1:0] w_mul_q_nx;

    always_comb begin
        w_m_ext   = r_uns ? {1'b0, r_m} : {r_m[WIDTH-1], r_m};
        w_mul_sum = r_acc;
        if (r_uns) begin
            // Plain shift-add: unsigned multiplier has no Booth recoding.
            if (r_q[0]) begin
                w_mul_sum = r_acc + w_m_ext;
            end
        end else begin
            case ({r_q[0], r_qm1})
                2'b01:   w_mul_sum = r_acc + w_m_ext;
                2'b10:   w_mul_sum = r_acc - w_m_ext;
                default: w_mul_sum = r_acc;
            endcase
        end
        // Arithmetic shift for signed, logical for unsigned.
        w_mul_fill   = r_uns ? 1'b0 : w_mul_sum[WIDTH];
        w_mul_acc_nx = {w_mul_fill, w_mul_sum[WIDTH:1]};
        w_mul_q_nx   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end

    // ---------------- divide iteration ----------------
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH:0]   w_div_acc_nx;
    logic [WIDTH-1:0] w_div_q_nx;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    always_comb begin
        w_rem_sh     = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        // Extra top bit acts as the borrow of the trial subtraction.
        w_div_diff   = {1'b0, w_rem_sh} - {2'b00, r_m};
        w_div_ge     = ~w_div_diff[WIDTH+1];
        w_div_acc_nx = w_div_ge ? w_div_diff[WIDTH:0] : w_rem_sh;
        w_div_q_nx   = {r_q[WIDTH-2:0], w_div_ge};
        w_quot       = r_neg_q ? -w_div_q_nx : w_div_q_nx;
        w_rem        = r_neg_r ? -w_div_acc_nx[WIDTH-1:0] : w_div_acc_nx[WIDTH-1:0];
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_m      <= '0;
            r_uns    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        r_uns <= w_uns;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_qm1 <= 1'b0;
                        if (!op_div) begin
                            r_m     <= src_a;
                            r_q     <= src_b;
                            busy    <= 1'b1;
                            r_state <= S_MULT;
                        end else if (src_b == '0) begin
                            // No iterations; outputs keep the previous result.
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_m     <= w_b_mag;
                            r_q     <= w_a_mag;
                            r_neg_q <= !w_uns && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            r_neg_r <= !w_uns && src_a[WIDTH-1];
                            busy    <= 1'b1;
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    r_acc <= w_mul_acc_nx;
                    r_q   <= w_mul_q_nx;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        hi_out  <= w_mul_acc_nx[WIDTH-1:0];
                        lo_out  <= w_mul_q_nx;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_acc_nx;
                    r_q   <= w_div_q_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        hi_out  <= w_rem;
                        lo_out  <= w_quot;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    // S_DONE: close the one-cycle pulses; a start here is dropped.
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed bench for mult_div_unit with hand-computed expected results.
// Expected {div_zero, hi, lo} triples are queued when an operation is issued
// and popped when done is observed. Inputs are driven on the falling edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic             clock;
    logic             reset;
    logic             start;
    logic             op_div;
    logic             op_unsigned;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [1:0]       o_dbg_state;

    int total_cnt;
    int bad_cnt;

    logic [2*WIDTH:0] exp_q[$];

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op_div      (op_div),
`ifdef MD_UNSIGNED_EN
        .op_unsigned (op_unsigned),
`endif
        .src_a       (src_a),
        .src_b       (src_b),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one operation and follows it to done. inject_at >= 0 pulses a
    // second (divide) start in the cycle after the sample at that offset, and
    // afterwards verifies that no extra done appears.
    task automatic run_op(input string name, input logic is_div, input logic uns,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int exp_lat, input int inject_at);
        int lat;
        int busy_cnt;
        int extra;
        logic seen;
        logic [2*WIDTH:0] e;
        exp_q.push_back({exp_dz, exp_hi, exp_lo});
        @(negedge clock);
        start       = 1'b1;
        op_div      = is_div;
        op_unsigned = uns;
        src_a       = a;
        src_b       = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
            @(negedge clock);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                lat++;
                if (busy) busy_cnt++;
                if (j == inject_at) begin
                    start  = 1'b1;
                    op_div = 1'b1;
                    src_a  = 32'd9;
                    src_b  = 32'd3;
                end
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        e = exp_q.pop_front();
        if (seen) begin
            check({name, "_latency"}, 32'(lat), 32'(exp_lat));
            check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
            check({name, "_busy_at_done"}, 32'(busy), 32'd0);
            check({name, "_hi"}, hi_out, e[63:32]);
            check({name, "_lo"}, lo_out, e[31:0]);
            check({name, "_div_zero"}, 32'(div_zero), 32'(e[64]));
            @(negedge clock);
            check({name, "_done_pulse"}, 32'(done), 32'd0);
            check({name, "_dz_cleared"}, 32'(div_zero), 32'd0);
            check({name, "_state_idle"}, 32'(o_dbg_state), 32'd0);
            check({name, "_hi_hold"}, hi_out, e[63:32]);
            check({name, "_lo_hold"}, lo_out, e[31:0]);
            if (inject_at >= 0) begin
                extra = 0;
                for (int j = 0; j < 40; j++) begin
                    @(negedge clock);
                    if (done) extra++;
                end
                check({name, "_extra_done"}, 32'(extra), 32'd0);
                check({name, "_hi_final"}, hi_out, e[63:32]);
                check({name, "_lo_final"}, lo_out, e[31:0]);
            end
        end
    endtask

    task automatic reset_mid_div();
        int extra;
        @(negedge clock);
        start  = 1'b1;
        op_div = 1'b1;
        op_unsigned = 1'b0;
        src_a  = 32'd100;
        src_b  = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clock);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_hi", hi_out, 32'd0);
        check("rst_mid_lo", lo_out, 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_dz", 32'(div_zero), 32'd0);
        check("rst_mid_state", 32'(o_dbg_state), 32'd0);
        reset = 1'b0;
        extra = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            if (done) extra++;
        end
        check("rst_mid_no_done", 32'(extra), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total_cnt   = 0;
        bad_cnt     = 0;
        reset       = 1'b1;
        start       = 1'b0;
        op_div      = 1'b0;
        op_unsigned = 1'b0;
        src_a       = '0;
        src_b       = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'd0);
        reset = 1'b0;

        //     name        div   uns   a              b              hi             lo             dz    lat inj
        run_op("mul_7_m3", 1'b0, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32, -1);
        run_op("mul_load", 1'b0, 1'b0, 32'h33333333, 32'h55555556, 32'h11111111, 32'h22222222, 1'b0, 32, -1);
        run_op("div_by_0", 1'b1, 1'b0, 32'd5,        32'd0,        32'h11111111, 32'h22222222, 1'b1, 0,  -1);
        run_op("div_m7_2", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32, -1);
        run_op("div_7_m2", 1'b1, 1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 32, -1);
        run_op("div_100_7",1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 32, -1);
        run_op("mul_min2", 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32, -1);
        run_op("div_minm1",1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 32, -1);
        run_op("mul_maxmin",1'b0,1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 32, -1);
        run_op("mul_m1_m1",1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 32, -1);
        run_op("mul_ignore",1'b0,1'b0, 32'h00001000, 32'h00002000, 32'd0,        32'h02000000, 1'b0, 32, 4);

        reset_mid_div();
        run_op("div_after_rst",1'b1,1'b0,32'd100,    32'd7,        32'd2,        32'd14,       1'b0, 32, -1);

`ifdef MD_UNSIGNED_EN
        run_op("multu",    1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, 1'b0, 32, -1);
        run_op("divu",     1'b1, 1'b1, 32'hFFFFFFFF, 32'd2,        32'd1,        32'h7FFFFFFF, 1'b0, 32, -1);
        run_op("mult_sgn", 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 32, -1);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
